ddr3_rx_bitslip_align: RTL and testbench

- Read-side counterpart to the DDR3 PHY output IOD lanes: consumes the per-pin deserialized RX_DATA words from the lane's input IODs.
- Trains word alignment per pin by pulsing RX_BIT_SLIP until a known training pattern is captured.
- After training, forwards aligned read data with a valid flag.
- Sits between the DQ lane IODs and the read-data FIFO / training controller in ddr3_DDRPHY_BLK.

---
 rtl/ddr3_phy_pkg.sv | 16 +
 rtl/ddr3_rx_bitslip_pin.sv | 98 +++++++++
 rtl/ddr3_rx_bitslip_align.sv | 80 ++++++++
 tb/tb_ddr3_rx_bitslip_align.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phy_pkg.sv
// Shared types and constants for the DDR3 PHY read-side alignment logic.
package ddr3_phy_pkg;

  localparam int CNT_W = 4;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hC5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_SLIP    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } pin_state_t;

endpackage

// File: rtl/ddr3_rx_bitslip_pin.sv
// Per-pin word-alignment trainer: compares the deserialized word against the
// training pattern and walks the IOD bitslip until it matches or runs out of rotations.
module ddr3_rx_bitslip_pin
  import ddr3_phy_pkg::*;
#(
  parameter int         RATIO         = 8,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SLIP_SETTLE   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             train_start,
  input  logic [RATIO-1:0] word,
  output logic             slip,
  output logic             locked,
  output logic             failed,
  output logic [CNT_W-1:0] slip_cnt
);

  localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_COUNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SLIP_SETTLE - 1);
  localparam logic [CNT_W-1:0] SLIP_MAX    = CNT_W'(RATIO - 1);
  localparam logic [RATIO-1:0] PATTERN     = TRAIN_PATTERN[RATIO-1:0];

  pin_state_t       state_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic [CNT_W-1:0] slip_cnt_r;
  logic [CNT_W-1:0] settle_cnt_r;
  logic             slip_r;

  // Pin FSM; slip_r is raised on entry to SLIP so the pulse covers exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      match_cnt_r  <= 4'd0;
      slip_cnt_r   <= 4'd0;
      settle_cnt_r <= 4'd0;
      slip_r       <= 1'b0;
    end else if (train_start) begin
      state_r      <= ST_COMPARE;
      match_cnt_r  <= 4'd0;
      slip_cnt_r   <= 4'd0;
      settle_cnt_r <= 4'd0;
      slip_r       <= 1'b0;
    end else begin
      slip_r <= 1'b0;
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_COMPARE: begin
          if (word == PATTERN) begin
            match_cnt_r <= match_cnt_r + 4'd1;
            if (match_cnt_r == MATCH_LAST) begin
              state_r <= ST_LOCKED;
            end else begin
              state_r <= ST_COMPARE;
            end
          end else begin
            match_cnt_r <= 4'd0;
            // All rotations tried once slip_cnt hits RATIO-1.
            if (slip_cnt_r == SLIP_MAX) begin
              state_r <= ST_FAIL;
            end else begin
              state_r <= ST_SLIP;
              slip_r  <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          if (slip_cnt_r != SLIP_MAX) begin
            slip_cnt_r <= slip_cnt_r + 4'd1;
          end else begin
            slip_cnt_r <= slip_cnt_r;
          end
          settle_cnt_r <= 4'd0;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ST_COMPARE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
            state_r      <= ST_WAIT;
          end
        end
        ST_LOCKED: state_r <= ST_LOCKED;
        ST_FAIL:   state_r <= ST_FAIL;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  assign slip     = slip_r;
  assign locked   = (state_r == ST_LOCKED);
  assign failed   = (state_r == ST_FAIL);
  assign slip_cnt = slip_cnt_r;

endmodule

// File: rtl/ddr3_rx_bitslip_align.sv
// DQ-lane read alignment: one bitslip trainer per pin, lane-wide status
// reduction and a one-cycle registered copy of the read data.
module ddr3_rx_bitslip_align
  import ddr3_phy_pkg::*;
#(
  parameter int         DQ_WIDTH      = 8,
  parameter int         RATIO         = 8,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SLIP_SETTLE   = 3
) (
  input  logic                      FAB_CLK,
  input  logic                      RX_SYNC_RST,
  input  logic                      TRAIN_START,
  input  logic [DQ_WIDTH*RATIO-1:0] RX_DATA_IN,
  output logic [DQ_WIDTH-1:0]       RX_BIT_SLIP,
  output logic [DQ_WIDTH*RATIO-1:0] RX_DATA_OUT,
  output logic                      RX_DATA_VALID,
  output logic                      TRAIN_DONE,
  output logic                      TRAIN_PASS,
  output logic [DQ_WIDTH-1:0]       PIN_FAIL,
  output logic [DQ_WIDTH*CNT_W-1:0] SLIP_COUNT
);

  logic [DQ_WIDTH-1:0]       locked_s;
  logic [DQ_WIDTH-1:0]       failed_s;
  logic [DQ_WIDTH*RATIO-1:0] data_r;
  logic                      valid_r;
  logic                      done_r;
  logic                      pass_r;
  logic [DQ_WIDTH-1:0]       fail_r;

  for (genvar p = 0; p < DQ_WIDTH; p++) begin : g_pin
    ddr3_rx_bitslip_pin #(
      .RATIO         (RATIO),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_SETTLE   (SLIP_SETTLE)
    ) u_pin (
      .clk         (FAB_CLK),
      .rst         (RX_SYNC_RST),
      .train_start (TRAIN_START),
      .word        (RX_DATA_IN[p*RATIO +: RATIO]),
      .slip        (RX_BIT_SLIP[p]),
      .locked      (locked_s[p]),
      .failed      (failed_s[p]),
      .slip_cnt    (SLIP_COUNT[p*CNT_W +: CNT_W])
    );
  end

  // Lane status and data register; status drops right away on a new TRAIN_START.
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= '0;
    end else begin
      data_r <= RX_DATA_IN;
      fail_r <= failed_s;
      if (TRAIN_START) begin
        valid_r <= 1'b0;
        done_r  <= 1'b0;
        pass_r  <= 1'b0;
      end else begin
        valid_r <= &locked_s;
        done_r  <= &(locked_s | failed_s);
        pass_r  <= &locked_s;
      end
    end
  end

  assign RX_DATA_OUT   = data_r;
  assign RX_DATA_VALID = valid_r;
  assign TRAIN_DONE    = done_r;
  assign TRAIN_PASS    = pass_r;
  assign PIN_FAIL      = fail_r;

endmodule

// File: tb/tb_ddr3_rx_bitslip_align.sv
// Bench for ddr3_rx_bitslip_align: IOD rotation model plus directed and randomized training runs.
module tb_ddr3_rx_bitslip_align;

  localparam int DQ_WIDTH    = 8;
  localparam int RATIO       = 8;
  localparam int MATCH_COUNT = 4;
  localparam int SLIP_SETTLE = 3;
  localparam logic [7:0] PATTERN = 8'hC5;

  logic                      FAB_CLK = 1'b0;
  logic                      RX_SYNC_RST;
  logic                      TRAIN_START;
  logic [DQ_WIDTH*RATIO-1:0] RX_DATA_IN;
  logic [DQ_WIDTH-1:0]       RX_BIT_SLIP;
  logic [DQ_WIDTH*RATIO-1:0] RX_DATA_OUT;
  logic                      RX_DATA_VALID;
  logic                      TRAIN_DONE;
  logic                      TRAIN_PASS;
  logic [DQ_WIDTH-1:0]       PIN_FAIL;
  logic [DQ_WIDTH*4-1:0]     SLIP_COUNT;

  int checks = 0;
  int errors = 0;

  int          base_rot   [DQ_WIDTH];
  int          applied    [DQ_WIDTH];
  int          pulses     [DQ_WIDTH];
  int          gap        [DQ_WIDTH];
  int          exp_slips  [DQ_WIDTH];
  logic        use_const  [DQ_WIDTH];
  logic [7:0]  const_word [DQ_WIDTH];
  logic [DQ_WIDTH-1:0] slip_d1, slip_d2, slip_last;

  always #5 FAB_CLK = ~FAB_CLK;

  ddr3_rx_bitslip_align #(
    .DQ_WIDTH      (DQ_WIDTH),
    .RATIO         (RATIO),
    .TRAIN_PATTERN (PATTERN),
    .MATCH_COUNT   (MATCH_COUNT),
    .SLIP_SETTLE   (SLIP_SETTLE)
  ) dut (
    .FAB_CLK       (FAB_CLK),
    .RX_SYNC_RST   (RX_SYNC_RST),
    .TRAIN_START   (TRAIN_START),
    .RX_DATA_IN    (RX_DATA_IN),
    .RX_BIT_SLIP   (RX_BIT_SLIP),
    .RX_DATA_OUT   (RX_DATA_OUT),
    .RX_DATA_VALID (RX_DATA_VALID),
    .TRAIN_DONE    (TRAIN_DONE),
    .TRAIN_PASS    (TRAIN_PASS),
    .PIN_FAIL      (PIN_FAIL),
    .SLIP_COUNT    (SLIP_COUNT)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    int k;
    k = ((n % 8) + 8) % 8;
    return (v << k) | (v >> (8 - k));
  endfunction

  // Rotation still separating pin p from alignment, as seen by the IOD model.
  function automatic int misalign(input int p);
    return (((base_rot[p] - applied[p]) % 8) + 8) % 8;
  endfunction

  task automatic drive_data();
    for (int p = 0; p < DQ_WIDTH; p++) begin
      RX_DATA_IN[p*8 +: 8] = use_const[p] ? const_word[p] : rotl8(PATTERN, misalign(p));
    end
  endtask

  task automatic set_rot(input int p, input int r);
    base_rot[p]  = applied[p] + r;
    use_const[p] = 1'b0;
    exp_slips[p] = r;
  endtask

  // One clock: check the data path, monitor slip pulses, advance the IOD model.
  task automatic tick();
    logic [63:0] in_s;
    logic        rst_s;
    in_s  = RX_DATA_IN;
    rst_s = RX_SYNC_RST;
    @(posedge FAB_CLK);
    #1;
    check_eq("data_out", RX_DATA_OUT, rst_s ? 64'd0 : in_s);
    for (int p = 0; p < DQ_WIDTH; p++) begin
      if (RX_BIT_SLIP[p]) begin
        check_eq("slip_width", {63'd0, slip_last[p]}, 64'd0);
        if (gap[p] >= 0) check_eq("slip_gap", gap[p], SLIP_SETTLE + 1);
        pulses[p]++;
        gap[p] = 0;
      end else if (gap[p] >= 0) begin
        gap[p]++;
      end
      if (slip_d2[p]) applied[p]++;
    end
    slip_last = RX_BIT_SLIP;
    slip_d2   = slip_d1;
    slip_d1   = RX_BIT_SLIP;
    drive_data();
  endtask

  task automatic clear_monitor();
    for (int p = 0; p < DQ_WIDTH; p++) begin
      pulses[p] = 0;
      gap[p]    = -1;
    end
  endtask

  task automatic train();
    clear_monitor();
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
    check_eq("done_drop", TRAIN_DONE, 1'b0);
    check_eq("valid_drop", RX_DATA_VALID, 1'b0);
  endtask

  task automatic wait_done(output int t);
    t = 1;
    while (!TRAIN_DONE && t < 200) begin
      tick();
      t++;
    end
    check_eq("done_timeout", TRAIN_DONE, 1'b1);
  endtask

  task automatic check_pins(input logic [7:0] exp_fail);
    check_eq("train_done", TRAIN_DONE, 1'b1);
    check_eq("train_pass", TRAIN_PASS, exp_fail == 8'd0);
    check_eq("data_valid", RX_DATA_VALID, exp_fail == 8'd0);
    check_eq("pin_fail", PIN_FAIL, exp_fail);
    for (int p = 0; p < DQ_WIDTH; p++) begin
      check_eq("slip_count", SLIP_COUNT[p*4 +: 4], exp_slips[p]);
      check_eq("slip_pulses", pulses[p], exp_slips[p]);
    end
  endtask

  initial begin
    int t;
    int n;
    int fp;
    logic [7:0] v;
    logic is_rot;

    for (int p = 0; p < DQ_WIDTH; p++) begin
      applied[p]    = 0;
      const_word[p] = 8'h00;
      set_rot(p, 0);
    end
    slip_d1 = '0;
    slip_d2 = '0;
    slip_last = '0;
    clear_monitor();
    RX_SYNC_RST = 1'b1;
    TRAIN_START = 1'b0;
    drive_data();

    repeat (3) tick();
    check_eq("rst_slip", RX_BIT_SLIP, 8'd0);
    check_eq("rst_done", TRAIN_DONE, 1'b0);
    check_eq("rst_pass", TRAIN_PASS, 1'b0);
    check_eq("rst_valid", RX_DATA_VALID, 1'b0);
    check_eq("rst_fail", PIN_FAIL, 8'd0);
    check_eq("rst_count", SLIP_COUNT, 32'd0);
    RX_SYNC_RST = 1'b0;
    repeat (2) tick();

    // Aligned lane: lock latency is MATCH_COUNT+2 with no slips.
    train();
    wait_done(t);
    check_eq("aligned_latency", t, MATCH_COUNT + 2);
    check_pins(8'h00);

    // Pin 3 rotated by 5.
    set_rot(3, 5);
    drive_data();
    train();
    wait_done(t);
    check_pins(8'h00);

    // Pin 0 stuck at zero: every rotation tried, then FAIL.
    for (int p = 0; p < DQ_WIDTH; p++) set_rot(p, 0);
    use_const[0]  = 1'b1;
    const_word[0] = 8'h00;
    exp_slips[0]  = RATIO - 1;
    drive_data();
    train();
    wait_done(t);
    check_pins(8'h01);

    // One corrupted word on pin 5 after two good compares.
    set_rot(0, 0);
    drive_data();
    train();
    tick();
    tick();
    use_const[5]  = 1'b1;
    const_word[5] = PATTERN ^ 8'h01;
    drive_data();
    use_const[5]  = 1'b0;
    n = 0;
    while (pulses[5] == 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("corrupt_slip", pulses[5], 1);
    check_eq("corrupt_nodone", TRAIN_DONE, 1'b0);
    repeat (3) tick();
    set_rot(5, 0);
    exp_slips[5] = 1;
    drive_data();
    wait_done(t);
    check_pins(8'h00);

    // Reset while pin 3 sits in WAIT after its first slip.
    set_rot(5, 0);
    set_rot(3, 4);
    drive_data();
    train();
    n = 0;
    while (pulses[3] == 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("wait_slip_seen", pulses[3], 1);
    tick();
    RX_SYNC_RST = 1'b1;
    tick();
    RX_SYNC_RST = 1'b0;
    check_eq("mid_rst_slip", RX_BIT_SLIP, 8'd0);
    check_eq("mid_rst_count", SLIP_COUNT, 32'd0);
    check_eq("mid_rst_done", TRAIN_DONE, 1'b0);
    check_eq("mid_rst_pass", TRAIN_PASS, 1'b0);
    check_eq("mid_rst_valid", RX_DATA_VALID, 1'b0);
    clear_monitor();
    repeat (12) tick();
    check_eq("post_rst_pulses", pulses[3], 0);
    check_eq("post_rst_count", SLIP_COUNT, 32'd0);
    exp_slips[3] = misalign(3);
    train();
    wait_done(t);
    check_pins(8'h00);

    // Restart while locked: status drops, then returns after MATCH_COUNT+2.
    exp_slips[3] = 0;
    train();
    wait_done(t);
    check_eq("relock_latency", t, MATCH_COUNT + 2);
    check_pins(8'h00);

    // Randomized rotations, with one stuck pin on odd trials.
    for (int trial = 0; trial < 6; trial++) begin
      for (int p = 0; p < DQ_WIDTH; p++) set_rot(p, $urandom_range(0, RATIO - 1));
      fp = -1;
      if (trial % 2 == 1) begin
        fp = $urandom_range(0, DQ_WIDTH - 1);
        do begin
          v = 8'($urandom_range(0, 255));
          is_rot = 1'b0;
          for (int r = 0; r < 8; r++) if (rotl8(PATTERN, r) == v) is_rot = 1'b1;
        end while (is_rot);
        use_const[fp]  = 1'b1;
        const_word[fp] = v;
        exp_slips[fp]  = RATIO - 1;
      end
      drive_data();
      train();
      wait_done(t);
      check_pins((fp >= 0) ? 8'(1 << fp) : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
